// File: rtl/pkt_id_pkg.sv
// pkt_id_pkg: byte-type codes, K-code constants and framing modes shared by the classifier
package pkt_id_pkg;
    localparam int TYPE_W = 3;
    typedef enum logic [TYPE_W-1:0] {
        BT_IDLE, BT_STP, BT_TLP_DATA, BT_SDP, BT_DLLP_DATA, BT_END, BT_EDB, BT_ERR
    } byte_type_t;
    typedef enum logic [1:0] {MODE_IDLE, MODE_TLP, MODE_DLLP} mode_t;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
endpackage

// File: rtl/pkt_id_byte_step.sv
// pkt_id_byte_step: one-byte framing next-state and type function
module pkt_id_byte_step
    import pkt_id_pkg::*;
#(
    parameter int DLLP_LEN    = 6,
    parameter int MAX_TLP_LEN = 4120,
    parameter int DCNT_W      = $clog2(DLLP_LEN + 1),
    parameter int TCNT_W      = $clog2(MAX_TLP_LEN + 1)
) (
    input  logic [7:0]        data,
    input  logic              dk,
    input  logic              bvalid,
    input  mode_t             mode,
    input  logic [DCNT_W-1:0] dllp_cnt,
    input  logic [TCNT_W-1:0] tlp_cnt,
    output byte_type_t        btype,
    output mode_t             nxt_mode,
    output logic [DCNT_W-1:0] nxt_dllp_cnt,
    output logic [TCNT_W-1:0] nxt_tlp_cnt
);
    always_comb begin
        btype = BT_IDLE;
        nxt_mode = mode;
        nxt_dllp_cnt = dllp_cnt;
        nxt_tlp_cnt = tlp_cnt;
        if (bvalid) begin
            case (mode)
                MODE_TLP: begin
                    nxt_mode = MODE_IDLE;
                    if (!dk && tlp_cnt != TCNT_W'(MAX_TLP_LEN)) begin
                        btype = BT_TLP_DATA;
                        nxt_mode = MODE_TLP;
                        nxt_tlp_cnt = tlp_cnt + 1'b1;
                    end else
                        btype = !dk ? BT_ERR : data == K_END ? BT_END : data == K_EDB ? BT_EDB : BT_ERR;
                end
                MODE_DLLP: begin
                    nxt_mode = MODE_IDLE;
                    if (!dk && dllp_cnt != DCNT_W'(DLLP_LEN)) begin
                        btype = BT_DLLP_DATA;
                        nxt_mode = MODE_DLLP;
                        nxt_dllp_cnt = dllp_cnt + 1'b1;
                    end else
                        btype = (dk && data == K_END && dllp_cnt == DCNT_W'(DLLP_LEN)) ? BT_END : BT_ERR;
                end
                default: begin
                    if (dk && data == K_STP) begin
                        btype = BT_STP;
                        nxt_mode = MODE_TLP;
                        nxt_tlp_cnt = '0;
                    end else if (dk && data == K_SDP) begin
                        btype = BT_SDP;
                        nxt_mode = MODE_DLLP;
                        nxt_dllp_cnt = '0;
                    end else
                        btype = (dk && (data == K_END || data == K_EDB)) ? BT_ERR : BT_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/pkt_id_datapath_pipe.sv
// pkt_id_datapath_pipe: registered per-byte packet framing classifier with valid/ready handshake
module pkt_id_datapath_pipe
    import pkt_id_pkg::*;
#(
    parameter int N_BYTES     = 64,
    parameter int DLLP_LEN    = 6,
    parameter int MAX_TLP_LEN = 4120,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*N_BYTES-1:0]      data_in,
    input  logic [N_BYTES-1:0]        dk_in,
    input  logic [N_BYTES-1:0]        bvalid_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [8*N_BYTES-1:0]      data_out,
    output logic [TYPE_W*N_BYTES-1:0] byte_type,
    output logic                      beat_err,
    output logic [ERR_CNT_W-1:0]      err_count
);
    localparam int DCNT_W = $clog2(DLLP_LEN + 1);
    localparam int TCNT_W = $clog2(MAX_TLP_LEN + 1);
    localparam int POP_W = $clog2(N_BYTES + 1);
    localparam int SUM_W = ERR_CNT_W + 1;
    mode_t mode_q;
    logic [DCNT_W-1:0] dllp_q;
    logic [TCNT_W-1:0] tlp_q;
    mode_t mode_c [N_BYTES+1];
    logic [DCNT_W-1:0] dllp_c [N_BYTES+1];
    logic [TCNT_W-1:0] tlp_c [N_BYTES+1];
    byte_type_t bt [N_BYTES];
    logic [TYPE_W*N_BYTES-1:0] types_c;
    logic [POP_W-1:0] err_pop;
    logic [SUM_W-1:0] err_sum;
    logic accept;
    assign in_ready = !out_valid || out_ready;
    assign accept = in_valid && in_ready;
    // flush makes a same-cycle beat start from IDLE
    assign mode_c[0] = flush ? MODE_IDLE : mode_q;
    assign dllp_c[0] = flush ? '0 : dllp_q;
    assign tlp_c[0] = flush ? '0 : tlp_q;
    for (genvar i = 0; i < N_BYTES; i++) begin : g_step
        pkt_id_byte_step #(
            .DLLP_LEN(DLLP_LEN), .MAX_TLP_LEN(MAX_TLP_LEN), .DCNT_W(DCNT_W), .TCNT_W(TCNT_W)
        ) u_step (
            .data(data_in[8*i +: 8]),
            .dk(dk_in[i]),
            .bvalid(bvalid_in[i]),
            .mode(mode_c[i]),
            .dllp_cnt(dllp_c[i]),
            .tlp_cnt(tlp_c[i]),
            .btype(bt[i]),
            .nxt_mode(mode_c[i+1]),
            .nxt_dllp_cnt(dllp_c[i+1]),
            .nxt_tlp_cnt(tlp_c[i+1])
        );
    end
    always_comb begin
        types_c = '0;
        err_pop = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            types_c[TYPE_W*i +: TYPE_W] = bt[i];
            err_pop = err_pop + POP_W'(bt[i] == BT_ERR);
        end
    end
    assign err_sum = {1'b0, err_count} + SUM_W'(err_pop);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            data_out <= '0;
            byte_type <= '0;
            beat_err <= 1'b0;
            err_count <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= data_in;
                byte_type <= types_c;
                beat_err <= |err_pop;
                err_count <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= MODE_IDLE;
            dllp_q <= '0;
            tlp_q <= '0;
        end else if (flush) begin
            mode_q <= MODE_IDLE;
            dllp_q <= '0;
            tlp_q <= '0;
        end else if (accept) begin
            mode_q <= mode_c[N_BYTES];
            dllp_q <= dllp_c[N_BYTES];
            tlp_q <= tlp_c[N_BYTES];
        end
    end
endmodule

// File: tb/tb_pkt_id_datapath_pipe.sv
// tb_pkt_id_datapath_pipe: directed scoreboard bench for the 4-byte packet classifier
module tb_pkt_id_datapath_pipe;
    logic clk, reset_n, flush, in_valid, in_ready, out_valid, out_ready, beat_err;
    logic [31:0] data_in, data_out;
    logic [3:0] dk_in, bvalid_in;
    logic [11:0] byte_type;
    logic [15:0] err_count;
    typedef struct {logic [31:0] d; logic [11:0] t; logic e;} exp_t;
    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int errs = 0;

    pkt_id_datapath_pipe #(.N_BYTES(4), .DLLP_LEN(6), .MAX_TLP_LEN(10), .ERR_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .dk_in(dk_in), .bvalid_in(bvalid_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .byte_type(byte_type), .beat_err(beat_err),
        .err_count(err_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [11:0] tv(input int a, input int b, input int c, input int d);
        return {d[2:0], c[2:0], b[2:0], a[2:0]};
    endfunction

    function automatic logic [31:0] dv(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sbq.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("data_out", data_out, e.d);
                chk("byte_type", 32'(byte_type), 32'(e.t));
                chk("beat_err", 32'(beat_err), 32'(e.e));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] bv,
                        input logic [11:0] t, input logic fl);
        exp_t e;
        int n;
        bit ok;
        @(posedge clk);
        #1;
        data_in = d; dk_in = k; bvalid_in = bv; flush = fl; in_valid = 1;
        n = 0;
        for (int i = 0; i < 4; i++) if (t[3*i +: 3] == 3'd7) n++;
        e.d = d; e.t = t; e.e = (n != 0);
        sbq.push_back(e);
        errs = (errs + n > 65535) ? 65535 : errs + n;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 0; flush = 0;
    endtask

    task automatic drain_chk(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'(errs));
    endtask

    initial begin
        reset_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        data_in = '0; dk_in = '0; bvalid_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_byte_type", 32'(byte_type), 32'd0);
        chk("rst_beat_err", 32'(beat_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 reset_n = 1;

        send(dv(8'hFB, 8'h01, 8'h02, 8'hFD), 4'b1001, 4'hF, tv(1, 2, 2, 5), 0);
        send(dv(8'h01, 8'h02, 8'h03, 8'h04), 4'b0000, 4'hF, tv(0, 0, 0, 0), 0);
        send(dv(8'h5C, 8'h10, 8'h11, 8'h12), 4'b0001, 4'hF, tv(3, 4, 4, 4), 0);
        send(dv(8'h13, 8'h14, 8'h15, 8'hFD), 4'b1000, 4'hF, tv(4, 4, 4, 5), 0);
        drain_chk("dllp_ok");
        send(dv(8'h5C, 8'h20, 8'h21, 8'h22), 4'b0001, 4'hF, tv(3, 4, 4, 4), 0);
        send(dv(8'h23, 8'hFD, 8'h00, 8'h00), 4'b0010, 4'hF, tv(4, 7, 0, 0), 0);
        drain_chk("dllp_short");

        @(posedge clk);
        #1 out_ready = 0;
        send(dv(8'hFB, 8'h30, 8'h31, 8'h32), 4'b0001, 4'hF, tv(1, 2, 2, 2), 0);
        @(posedge clk);
        #1;
        data_in = dv(8'h33, 8'h34, 8'h35, 8'h36); dk_in = 4'b0000; bvalid_in = 4'hF; in_valid = 1;
        begin
            exp_t e;
            e.d = data_in; e.t = tv(2, 2, 2, 2); e.e = 0;
            sbq.push_back(e);
        end
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_data_out", data_out, dv(8'hFB, 8'h30, 8'h31, 8'h32));
            chk("stall_byte_type", 32'(byte_type), 32'(tv(1, 2, 2, 2)));
        end
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1 in_valid = 0;
        drain_chk("stall");

        @(posedge clk);
        #1 reset_n = 0;
        errs = 0;
        #2;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1 reset_n = 1;
        send(dv(8'h40, 8'h41, 8'h42, 8'h43), 4'b0000, 4'hF, tv(0, 0, 0, 0), 0);
        drain_chk("post_rst");

        send(dv(8'hFB, 8'h50, 8'h51, 8'h52), 4'b0001, 4'hF, tv(1, 2, 2, 2), 0);
        send(dv(8'h53, 8'hAA, 8'h54, 8'hBB), 4'b0000, 4'b0101, tv(2, 0, 2, 0), 0);
        send(dv(8'h55, 8'h56, 8'h57, 8'h58), 4'b0000, 4'hF, tv(2, 2, 2, 2), 0);
        send(dv(8'h60, 8'h61, 8'h62, 8'h63), 4'b0000, 4'hF, tv(2, 7, 0, 0), 0);
        drain_chk("tlp_max");
        send(dv(8'hFB, 8'h70, 8'h71, 8'h72), 4'b0001, 4'hF, tv(1, 2, 2, 2), 0);
        send(dv(8'hFB, 8'h73, 8'h74, 8'h75), 4'b0001, 4'hF, tv(1, 2, 2, 2), 1);
        send(dv(8'h76, 8'hFD, 8'h77, 8'h78), 4'b0010, 4'hF, tv(0, 7, 0, 0), 0);
        drain_chk("flush");

        for (int i = 0; i < 16384; i++)
            send(dv(8'hFD, 8'hFD, 8'hFD, 8'hFD), 4'hF, 4'hF, tv(7, 7, 7, 7), 0);
        drain_chk("saturate");
        chk("saturate_all_ones", 32'(err_count), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
